// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, funct codes and ALUOp encodings used by the
// operand stage, the ALU and the main control unit.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int REG_N  = 2 ** ADDR_W;
  localparam int IMM_W  = 16;
  localparam int OP_W   = 4;
  localparam int FUNCT_W = 6;

  typedef logic [OP_W-1:0]    alu_op_t;
  typedef logic [FUNCT_W-1:0] funct_t;

  // ALU op codes
  localparam alu_op_t OP_AND = 4'b0000;
  localparam alu_op_t OP_OR  = 4'b0001;
  localparam alu_op_t OP_ADD = 4'b0010;
  localparam alu_op_t OP_SUB = 4'b0110;
  localparam alu_op_t OP_SLT = 4'b0111;
  localparam alu_op_t OP_NOR = 4'b1100;

  // R-type funct field values
  localparam funct_t FUNCT_ADD = 6'b100000;
  localparam funct_t FUNCT_SUB = 6'b100010;
  localparam funct_t FUNCT_AND = 6'b100100;
  localparam funct_t FUNCT_OR  = 6'b100101;
  localparam funct_t FUNCT_SLT = 6'b101010;
  localparam funct_t FUNCT_NOR = 6'b100111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Issue-stage bus: instruction fields and writeback port in, registered ALU
// inputs out. master = upstream driver, slave = operand stage.
interface alu_operand_stage_if;
  import alu_pkg::*;

  logic                i_valid;
  logic                i_stall;
  logic                i_flush;
  logic [ADDR_W-1:0]   i_u5_rs;
  logic [ADDR_W-1:0]   i_u5_rt;
  logic [1:0]          i_u2_aluop;
  funct_t              i_u6_funct;
  logic                i_alusrc;
  logic [IMM_W-1:0]    i_u16_imm;
  logic                i_we;
  logic [ADDR_W-1:0]   i_u5_wa;
  logic [DATA_W-1:0]   i_u32_wd;

  logic                o_valid;
  alu_op_t             o_u4_op;
  logic [DATA_W-1:0]   o_u32_din1;
  logic [DATA_W-1:0]   o_u32_din2;
  logic                o_illegal;

  modport master (
    output i_valid, i_stall, i_flush, i_u5_rs, i_u5_rt, i_u2_aluop, i_u6_funct,
           i_alusrc, i_u16_imm, i_we, i_u5_wa, i_u32_wd,
    input  o_valid, o_u4_op, o_u32_din1, o_u32_din2, o_illegal
  );

  modport slave (
    input  i_valid, i_stall, i_flush, i_u5_rs, i_u5_rt, i_u2_aluop, i_u6_funct,
           i_alusrc, i_u16_imm, i_we, i_u5_wa, i_u32_wd,
    output o_valid, o_u4_op, o_u32_din1, o_u32_din2, o_illegal
  );

endinterface

// File: rtl/regfile_2r1w.sv
// 2-read / 1-write register file with hard-wired zero r0, synchronous reset and
// write-through bypass so a same-cycle write is visible on the read ports.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int REG_N  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [ADDR_W-1:0] ra1_i,
  input  logic [ADDR_W-1:0] ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
);

  logic [DATA_W-1:0] mem_q [REG_N];
  logic              wr_en;

  assign wr_en = we_i && (wa_i != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == '0)              ? '0   :
                 (wr_en && wa_i == ra1_i)   ? wd_i :
                                              mem_q[ra1_i];

  assign rd2_o = (ra2_i == '0)              ? '0   :
                 (wr_en && wa_i == ra2_i)   ? wd_i :
                                              mem_q[ra2_i];

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage feeding the ALU: register read, ALUOp/funct decode, imm16 select,
// and a 1-cycle output register with flush/stall and stall-time operand refresh.
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  alu_operand_stage_if.slave bus
);

  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .REG_N  (REG_N)
  ) u_regfile (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .we_i   (bus.i_we),
    .wa_i   (bus.i_u5_wa),
    .wd_i   (bus.i_u32_wd),
    .ra1_i  (bus.i_u5_rs),
    .ra2_i  (bus.i_u5_rt),
    .rd1_o  (rd1),
    .rd2_o  (rd2)
  );

  alu_op_t dec_op;
  logic    dec_ill;

  always_comb begin
    dec_op  = OP_AND;
    dec_ill = 1'b0;
    case (aluop_e'(bus.i_u2_aluop))
      ALUOP_ADD: dec_op = OP_ADD;
      ALUOP_SUB: dec_op = OP_SUB;
      ALUOP_OR:  dec_op = OP_OR;
      ALUOP_FUNCT: begin
        case (bus.i_u6_funct)
          FUNCT_ADD: dec_op = OP_ADD;
          FUNCT_SUB: dec_op = OP_SUB;
          FUNCT_AND: dec_op = OP_AND;
          FUNCT_OR:  dec_op = OP_OR;
          FUNCT_SLT: dec_op = OP_SLT;
          FUNCT_NOR: dec_op = OP_NOR;
          default: begin
            dec_op  = OP_AND;
            dec_ill = 1'b1;
          end
        endcase
      end
      default: dec_op = OP_AND;
    endcase
  end

  logic [DATA_W-1:0] opnd2;
  logic              wb_hit;

  assign opnd2  = bus.i_alusrc ? sext_imm(bus.i_u16_imm) : rd2;
  assign wb_hit = bus.i_we && (bus.i_u5_wa != '0);

  logic              valid_q, valid_d;
  alu_op_t           op_q, op_d;
  logic [DATA_W-1:0] din1_q, din1_d;
  logic [DATA_W-1:0] din2_q, din2_d;
  logic              ill_q, ill_d;
  logic [ADDR_W-1:0] hrs_q, hrs_d;
  logic [ADDR_W-1:0] hrt_q, hrt_d;
  logic              hsrc_q, hsrc_d;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    din1_d  = din1_q;
    din2_d  = din2_q;
    ill_d   = ill_q;
    hrs_d   = hrs_q;
    hrt_d   = hrt_q;
    hsrc_d  = hsrc_q;
    if (bus.i_flush) begin
      valid_d = 1'b0;
      ill_d   = 1'b0;
    end else if (bus.i_stall) begin
      // A held instruction must not miss a writeback that lands while it waits.
      if (valid_q && wb_hit) begin
        if (bus.i_u5_wa == hrs_q) begin
          din1_d = bus.i_u32_wd;
        end
        if (bus.i_u5_wa == hrt_q && !hsrc_q) begin
          din2_d = bus.i_u32_wd;
        end
      end
    end else begin
      valid_d = bus.i_valid;
      op_d    = dec_op;
      din1_d  = rd1;
      din2_d  = opnd2;
      ill_d   = bus.i_valid && dec_ill;
      hrs_d   = bus.i_u5_rs;
      hrt_d   = bus.i_u5_rt;
      hsrc_d  = bus.i_alusrc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      op_q    <= OP_AND;
      din1_q  <= '0;
      din2_q  <= '0;
      ill_q   <= 1'b0;
      hrs_q   <= '0;
      hrt_q   <= '0;
      hsrc_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      din1_q  <= din1_d;
      din2_q  <= din2_d;
      ill_q   <= ill_d;
      hrs_q   <= hrs_d;
      hrt_q   <= hrt_d;
      hsrc_q  <= hsrc_d;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_u4_op    = op_q;
  assign bus.o_u32_din1 = din1_q;
  assign bus.o_u32_din2 = din2_q;
  assign bus.o_illegal  = ill_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed cases with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_operand_stage_if ifc ();

  alu_operand_stage dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc)
  );

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
  logic [3:0] op_tab [6] = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111,   4'b1100};

  // Model state: architectural registers plus what the output register must hold.
  logic [31:0] m_rf [32];
  logic        e_valid, e_ill, e_known;
  logic [3:0]  e_op;
  logic [31:0] e_d1, e_d2;
  logic [4:0]  h_rs, h_rt;
  logic        h_src;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] m_dec(input logic [1:0] a, input logic [5:0] f);
    if (a == 2'd0) return {1'b0, 4'd2};
    if (a == 2'd1) return {1'b0, 4'd6};
    if (a == 2'd3) return {1'b0, 4'd1};
    for (int k = 0; k < 6; k++) begin
      if (fn_tab[k] == f) return {1'b0, op_tab[k]};
    end
    return {1'b1, 4'd0};
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (ifc.i_we && ifc.i_u5_wa == r) return ifc.i_u32_wd;
    return m_rf[r];
  endfunction

  task automatic model_step();
    logic [31:0] a, b;
    logic [4:0]  d;
    a = m_rd(ifc.i_u5_rs);
    b = ifc.i_alusrc ? {{16{ifc.i_u16_imm[15]}}, ifc.i_u16_imm} : m_rd(ifc.i_u5_rt);
    d = m_dec(ifc.i_u2_aluop, ifc.i_u6_funct);
    if (rst) begin
      for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
      e_valid = 0; e_ill = 0; e_op = 0; e_d1 = 0; e_d2 = 0; e_known = 1;
      h_rs = 0; h_rt = 0; h_src = 0;
      return;
    end
    if (ifc.i_flush) begin
      e_valid = 0; e_ill = 0; e_known = 0;
    end else if (ifc.i_stall) begin
      if (e_valid && ifc.i_we && ifc.i_u5_wa != 0) begin
        if (ifc.i_u5_wa == h_rs) e_d1 = ifc.i_u32_wd;
        if (ifc.i_u5_wa == h_rt && !h_src) e_d2 = ifc.i_u32_wd;
      end
    end else begin
      e_valid = ifc.i_valid;
      e_op = d[3:0]; e_d1 = a; e_d2 = b;
      e_ill = ifc.i_valid && d[4];
      e_known = ifc.i_valid;
      h_rs = ifc.i_u5_rs; h_rt = ifc.i_u5_rt; h_src = ifc.i_alusrc;
    end
    if (ifc.i_we && ifc.i_u5_wa != 0) m_rf[ifc.i_u5_wa] = ifc.i_u32_wd;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", 32'(ifc.o_valid), 32'(e_valid));
      chk("m_illegal", 32'(ifc.o_illegal), 32'(e_ill));
      if (e_known) begin
        chk("m_op", 32'(ifc.o_u4_op), 32'(e_op));
        chk("m_din1", ifc.o_u32_din1, e_d1);
        chk("m_din2", ifc.o_u32_din2, e_d2);
      end
    end
  end

  task automatic idle();
    rst = 0;
    ifc.i_valid = 0; ifc.i_stall = 0; ifc.i_flush = 0;
    ifc.i_u5_rs = 0; ifc.i_u5_rt = 0; ifc.i_u2_aluop = 0; ifc.i_u6_funct = 0;
    ifc.i_alusrc = 0; ifc.i_u16_imm = 0;
    ifc.i_we = 0; ifc.i_u5_wa = 0; ifc.i_u32_wd = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    idle();
    chk_en = 1;

    // Reset with a valid instruction presented
    rst = 1; ifc.i_valid = 1; ifc.i_u2_aluop = 2'b01; tick();
    chk("rst_valid", 32'(ifc.o_valid), 32'd0);
    chk("rst_op", 32'(ifc.o_u4_op), 32'd0);
    chk("rst_din1", ifc.o_u32_din1, 32'd0);
    chk("rst_din2", ifc.o_u32_din2, 32'd0);
    chk("rst_ill", 32'(ifc.o_illegal), 32'd0);
    for (int i = 1; i < 32; i++) begin
      idle(); ifc.i_valid = 1; ifc.i_u5_rs = 5'(i); ifc.i_u5_rt = 5'(32 - i); tick();
      chk("rst_rf_rs", ifc.o_u32_din1, 32'd0);
      chk("rst_rf_rt", ifc.o_u32_din2, 32'd0);
    end

    // Write r5 then read it through funct OR
    idle(); ifc.i_we = 1; ifc.i_u5_wa = 5; ifc.i_u32_wd = 32'h0000_00A5; tick();
    idle(); ifc.i_valid = 1; ifc.i_u5_rs = 5; ifc.i_u2_aluop = 2'b10; ifc.i_u6_funct = 6'b100101; tick();
    chk("or_op", 32'(ifc.o_u4_op), 32'h1);
    chk("or_din1", ifc.o_u32_din1, 32'h0000_00A5);
    chk("or_din2", ifc.o_u32_din2, 32'h0);
    chk("or_valid", 32'(ifc.o_valid), 32'd1);

    // Bypass, and r0 stays zero
    idle(); ifc.i_valid = 1; ifc.i_we = 1; ifc.i_u5_wa = 7; ifc.i_u32_wd = 32'h1234; ifc.i_u5_rs = 7; tick();
    chk("byp_din1", ifc.o_u32_din1, 32'h1234);
    idle(); ifc.i_valid = 1; ifc.i_we = 1; ifc.i_u5_wa = 0; ifc.i_u32_wd = 32'hFFFF_FFFF; tick();
    chk("r0_byp", ifc.o_u32_din1, 32'h0);
    idle(); ifc.i_valid = 1; tick();
    chk("r0_read", ifc.o_u32_din1, 32'h0);

    // Immediate sign extension, negative and positive
    idle(); ifc.i_valid = 1; ifc.i_alusrc = 1; ifc.i_u16_imm = 16'hFFF0; ifc.i_u5_rt = 7; tick();
    chk("imm_op", 32'(ifc.o_u4_op), 32'h2);
    chk("imm_neg", ifc.o_u32_din2, 32'hFFFF_FFF0);
    idle(); ifc.i_valid = 1; ifc.i_alusrc = 1; ifc.i_u16_imm = 16'h7FFF; tick();
    chk("imm_pos", ifc.o_u32_din2, 32'h0000_7FFF);

    // Stall refresh of held rs, then rt
    idle(); ifc.i_valid = 1; ifc.i_u5_rs = 3; ifc.i_u5_rt = 4; ifc.i_u2_aluop = 2'b01; tick();
    idle(); ifc.i_stall = 1; ifc.i_valid = 1; ifc.i_u5_rs = 9; ifc.i_u2_aluop = 2'b11;
    ifc.i_we = 1; ifc.i_u5_wa = 3; ifc.i_u32_wd = 32'hDEAD_BEEF; tick();
    chk("stl_din1", ifc.o_u32_din1, 32'hDEAD_BEEF);
    chk("stl_din2", ifc.o_u32_din2, 32'h0);
    chk("stl_op", 32'(ifc.o_u4_op), 32'h6);
    chk("stl_valid", 32'(ifc.o_valid), 32'd1);
    idle(); ifc.i_stall = 1; ifc.i_we = 1; ifc.i_u5_wa = 4; ifc.i_u32_wd = 32'hCAFE_F00D; tick();
    chk("stl_rt", ifc.o_u32_din2, 32'hCAFE_F00D);
    chk("stl_rs_kept", ifc.o_u32_din1, 32'hDEAD_BEEF);
    // Held immediate operand must ignore a write to its rt
    idle(); ifc.i_valid = 1; ifc.i_u5_rs = 5; ifc.i_u5_rt = 7; ifc.i_alusrc = 1; ifc.i_u16_imm = 16'h0010; tick();
    idle(); ifc.i_stall = 1; ifc.i_we = 1; ifc.i_u5_wa = 7; ifc.i_u32_wd = 32'h55; tick();
    chk("stl_imm_din2", ifc.o_u32_din2, 32'h10);
    chk("stl_imm_din1", ifc.o_u32_din1, 32'hA5);

    // Every legal funct
    for (int k = 0; k < 6; k++) begin
      idle(); ifc.i_valid = 1; ifc.i_u2_aluop = 2'b10; ifc.i_u6_funct = fn_tab[k]; tick();
      chk("funct_op", 32'(ifc.o_u4_op), 32'(op_tab[k]));
      chk("funct_ill", 32'(ifc.o_illegal), 32'd0);
    end

    // Unknown funct, then flush+stall, then stall while empty
    idle(); ifc.i_valid = 1; ifc.i_u2_aluop = 2'b10; ifc.i_u6_funct = 6'b000000; tick();
    chk("ill_op", 32'(ifc.o_u4_op), 32'h0);
    chk("ill_flag", 32'(ifc.o_illegal), 32'd1);
    idle(); ifc.i_flush = 1; ifc.i_stall = 1; ifc.i_valid = 1; tick();
    chk("fl_valid", 32'(ifc.o_valid), 32'd0);
    chk("fl_ill", 32'(ifc.o_illegal), 32'd0);
    idle(); ifc.i_stall = 1; ifc.i_valid = 1; tick();
    chk("stl_empty_valid", 32'(ifc.o_valid), 32'd0);

    // Reset wins over a stall
    idle(); ifc.i_valid = 1; ifc.i_u5_rs = 5; tick();
    idle(); rst = 1; ifc.i_stall = 1; tick();
    chk("rst_stl_valid", 32'(ifc.o_valid), 32'd0);
    chk("rst_stl_din1", ifc.o_u32_din1, 32'd0);

    // Randomized traffic; narrow register range to exercise bypass and refresh
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      ifc.i_valid    = ($urandom_range(0, 3) != 0);
      ifc.i_stall    = ($urandom_range(0, 3) == 0);
      ifc.i_flush    = ($urandom_range(0, 7) == 0);
      ifc.i_u5_rs    = 5'($urandom_range(0, 7));
      ifc.i_u5_rt    = 5'($urandom_range(0, 7));
      ifc.i_u2_aluop = 2'($urandom_range(0, 3));
      ifc.i_u6_funct = $urandom_range(0, 1) ? fn_tab[$urandom_range(0, 5)] : 6'($urandom_range(0, 63));
      ifc.i_alusrc   = 1'($urandom_range(0, 1));
      ifc.i_u16_imm  = 16'($urandom);
      ifc.i_we       = 1'($urandom_range(0, 1));
      ifc.i_u5_wa    = 5'($urandom_range(0, 7));
      ifc.i_u32_wd   = $urandom;
      tick();
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
